// File: rtl/tage_update_ctrl.sv
// Buffers resolved-branch records and sequences provider update and mispredict
// allocation writes into the TAGE tables. Optional macro: TAGE_ALLOC_PARALLEL_EN.
module tage_update_ctrl #(
  parameter int NUM_TABLES = 4,
  parameter int IDX_W      = 6,
  parameter int TAG_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PROV_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        IN_valid,
  output logic                        OUT_ready,
  input  logic [NUM_TABLES*IDX_W-1:0] IN_idx,
  input  logic [NUM_TABLES*TAG_W-1:0] IN_tag,
  input  logic                        IN_provValid,
  input  logic [PROV_W-1:0]           IN_provIdx,
  input  logic                        IN_provPred,
  input  logic                        IN_altPred,
  input  logic                        IN_taken,
  output logic [NUM_TABLES-1:0]       OUT_writeValid,
  output logic [NUM_TABLES*IDX_W-1:0] OUT_writeAddr,
  output logic [NUM_TABLES*TAG_W-1:0] OUT_writeTag,
  output logic                        OUT_writeTaken,
  output logic                        OUT_writeNew,
  output logic                        OUT_writeUpdate,
  output logic                        OUT_writeUseful,
  output logic                        OUT_anyAlloc,
  input  logic [NUM_TABLES-1:0]       IN_writeAlloc,
  output logic                        OUT_allocFail,
  output logic                        OUT_idle
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PROV_W-1:0] LAST_T   = PROV_W'(NUM_TABLES - 1);

  typedef struct packed {
    logic [NUM_TABLES*IDX_W-1:0] idx;
    logic [NUM_TABLES*TAG_W-1:0] tag;
    logic                        prov_valid;
    logic [PROV_W-1:0]           prov_idx;
    logic                        prov_pred;
    logic                        alt_pred;
    logic                        taken;
  } rec_t;

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_ALLOC} state_t;

  function automatic logic mispred(input rec_t r);
    return (r.prov_valid ? r.prov_pred : r.alt_pred) != r.taken;
  endfunction

  rec_t                        fifo_mem_q [FIFO_DEPTH];
  rec_t                        in_rec, head, cur_q, cur_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]              count_q, count_d;
  state_t                      state_q, state_d;
  logic                        push, pop;
  logic [NUM_TABLES-1:0]       wv_q, wv_d;
  logic [NUM_TABLES*IDX_W-1:0] addr_q, addr_d;
  logic [NUM_TABLES*TAG_W-1:0] tag_q, tag_d;
  logic                        taken_q, taken_d, new_q, new_d;
  logic                        update_q, update_d, useful_q, useful_d;
  logic                        fail_q, fail_d;
`ifndef TAGE_ALLOC_PARALLEL_EN
  logic [PROV_W-1:0]           probe_q, probe_d;
`endif

  assign OUT_ready = (count_q != FULL_CNT);
  assign push      = IN_valid && OUT_ready;
  assign head      = fifo_mem_q[rd_ptr_q];

  always_comb begin
    in_rec = '{idx: IN_idx, tag: IN_tag, prov_valid: IN_provValid, prov_idx: IN_provIdx,
               prov_pred: IN_provPred, alt_pred: IN_altPred, taken: IN_taken};
    pop     = 1'b0;
    state_d = state_q;
    cur_d   = cur_q;
    fail_d  = 1'b0;
`ifndef TAGE_ALLOC_PARALLEL_EN
    probe_d = probe_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop   = 1'b1;
          cur_d = head;
          if (head.prov_valid) begin
            state_d = S_UPDATE;
          end else if (mispred(head)) begin
            state_d = S_ALLOC;
`ifndef TAGE_ALLOC_PARALLEL_EN
            probe_d = '0;
`endif
          end
        end
      end
      S_UPDATE: begin
        state_d = S_IDLE;
        if (mispred(cur_q) && cur_q.prov_idx < LAST_T) begin
          state_d = S_ALLOC;
`ifndef TAGE_ALLOC_PARALLEL_EN
          probe_d = cur_q.prov_idx + PROV_W'(1);
`endif
        end
      end
      S_ALLOC: begin
`ifdef TAGE_ALLOC_PARALLEL_EN
        state_d = S_IDLE;
        fail_d  = !(|(IN_writeAlloc & wv_q));
`else
        if (IN_writeAlloc[probe_q]) begin
          state_d = S_IDLE;
        end else if (probe_q == LAST_T) begin
          state_d = S_IDLE;
          fail_d  = 1'b1;
        end else begin
          probe_d = probe_q + PROV_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase

    // Write-port outputs are registered so they line up with the state they describe.
    wv_d     = '0;
    addr_d   = '0;
    tag_d    = '0;
    taken_d  = 1'b0;
    new_d    = 1'b0;
    update_d = 1'b0;
    useful_d = 1'b0;
    case (state_d)
      S_UPDATE: begin
        wv_d[cur_d.prov_idx] = 1'b1;
        update_d = 1'b1;
        useful_d = (cur_d.prov_pred == cur_d.taken);
        taken_d  = cur_d.taken;
      end
      S_ALLOC: begin
        new_d   = 1'b1;
        taken_d = cur_d.taken;
`ifdef TAGE_ALLOC_PARALLEL_EN
        for (int t = 0; t < NUM_TABLES; t++)
          wv_d[t] = !cur_d.prov_valid || (t > int'(cur_d.prov_idx));
`else
        wv_d[probe_d] = 1'b1;
`endif
      end
      default: ;
    endcase
    for (int t = 0; t < NUM_TABLES; t++) begin
      if (wv_d[t]) begin
        addr_d[t*IDX_W +: IDX_W] = cur_d.idx[t*IDX_W +: IDX_W];
        tag_d[t*TAG_W +: TAG_W]  = cur_d.tag[t*TAG_W +: TAG_W];
      end
    end
  end

  // Record storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= in_rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wv_q     <= '0;
      addr_q   <= '0;
      tag_q    <= '0;
      taken_q  <= 1'b0;
      new_q    <= 1'b0;
      update_q <= 1'b0;
      useful_q <= 1'b0;
      fail_q   <= 1'b0;
`ifndef TAGE_ALLOC_PARALLEL_EN
      probe_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wv_q     <= wv_d;
      addr_q   <= addr_d;
      tag_q    <= tag_d;
      taken_q  <= taken_d;
      new_q    <= new_d;
      update_q <= update_d;
      useful_q <= useful_d;
      fail_q   <= fail_d;
`ifndef TAGE_ALLOC_PARALLEL_EN
      probe_q  <= probe_d;
`endif
    end
  end

  assign OUT_writeValid  = wv_q;
  assign OUT_writeAddr   = addr_q;
  assign OUT_writeTag    = tag_q;
  assign OUT_writeTaken  = taken_q;
  assign OUT_writeNew    = new_q;
  assign OUT_writeUpdate = update_q;
  assign OUT_writeUseful = useful_q;
  assign OUT_allocFail   = fail_q;
  assign OUT_idle        = (count_q == '0) && (state_q == S_IDLE);
`ifdef TAGE_ALLOC_PARALLEL_EN
  assign OUT_anyAlloc    = new_q && (|(IN_writeAlloc & wv_q));
`else
  assign OUT_anyAlloc    = 1'b0;
`endif

endmodule
